stoch_signed_pool: RTL and testbench

//  Parametrised stochastic signed-bitstream 2-D pooling layer; successor to the combinational-patch maxpool.

---
 rtl/stoch_signed_pool_pkg.sv | 22 ++
 rtl/stoch_signed_pool_unit.sv | 111 +++++++++++
 rtl/stoch_signed_pool.sv | 95 +++++++++
 tb/tb_stoch_signed_pool.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/stoch_signed_pool_pkg.sv
// Shared types and elaboration-time helpers for the stochastic signed pooling layer.
package stoch_pool_pkg;

   typedef enum logic {
      POOL_MAX = 1'b0,
      POOL_AVG = 1'b1
   } mode_e;

   function automatic int clog2_f(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < v) r = i + 1;
      end
      return r;
   endfunction

   function automatic int out_dim(input int im, input int pad, input int k, input int stride);
      return (im + 2 * pad - k) / stride + 1;
   endfunction

endpackage

// File: rtl/stoch_signed_pool_unit.sv
// One pooling window: per-tap saturating leader counters for max mode and a
// signed remainder accumulator for average mode, with a registered output bit pair.
module stoch_signed_pool_unit
   import stoch_pool_pkg::*;
#(
   parameter int           N        = 4,
   parameter int           CNT_W    = 8,
   parameter logic [N-1:0] PAD_MASK = '0
) (
   input  logic         clk,
   input  logic         srst,
   input  logic         mode,
   input  logic         clr,
   input  logic         in_valid,
   input  logic [N-1:0] tap_p,
   input  logic [N-1:0] tap_m,
   output logic         y_p,
   output logic         y_m
);

   localparam int ACC_W = clog2_f(N) + 3;
   localparam int IDX_W = (N > 1) ? clog2_f(N) : 1;
   localparam logic signed [CNT_W:0]   SAT_HI = (CNT_W + 1)'((1 << (CNT_W - 1)) - 1);
   localparam logic signed [CNT_W:0]   SAT_LO = -SAT_HI;
   localparam logic signed [ACC_W-1:0] N_S    = ACC_W'(N);

   logic signed [1:0]       d         [N];
   logic signed [CNT_W:0]   cnt_sum   [N];
   logic signed [CNT_W-1:0] cnt_next  [N];
   logic signed [CNT_W-1:0] cnt_reg   [N];

   logic [IDX_W-1:0]        lead_idx;
   logic signed [CNT_W-1:0] lead_val;
   logic                    lead_found;

   logic signed [ACC_W-1:0] acc_reg, acc_next, tap_sum, acc_sum;
   logic                    avg_p, avg_m;
   logic                    y_p_reg, y_m_reg;

   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_tap
         // Pad taps contribute zero and so their counters never leave reset.
         assign d[gi] = PAD_MASK[gi] ? 2'sd0
                                     : ($signed({1'b0, tap_p[gi]}) - $signed({1'b0, tap_m[gi]}));
         assign cnt_sum[gi]  = (CNT_W + 1)'(cnt_reg[gi]) + (CNT_W + 1)'(d[gi]);
         assign cnt_next[gi] = (cnt_sum[gi] > SAT_HI) ? SAT_HI[CNT_W-1:0] :
                               (cnt_sum[gi] < SAT_LO) ? SAT_LO[CNT_W-1:0] :
                                                        cnt_sum[gi][CNT_W-1:0];
      end
   endgenerate

   // Strict greater-than keeps the lowest flat index on ties.
   always_comb begin
      lead_idx   = '0;
      lead_val   = '0;
      lead_found = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (!PAD_MASK[i] && (!lead_found || cnt_reg[i] > lead_val)) begin
            lead_idx   = IDX_W'(i);
            lead_val   = cnt_reg[i];
            lead_found = 1'b1;
         end
      end
   end

   always_comb begin
      tap_sum = '0;
      for (int i = 0; i < N; i++) begin
         tap_sum = tap_sum + ACC_W'(d[i]);
      end
      acc_sum  = acc_reg + tap_sum;
      avg_p    = 1'b0;
      avg_m    = 1'b0;
      acc_next = acc_sum;
      if (acc_sum >= N_S) begin
         avg_p    = 1'b1;
         acc_next = acc_sum - N_S;
      end else if (acc_sum <= -N_S) begin
         avg_m    = 1'b1;
         acc_next = acc_sum + N_S;
      end
   end

   // Both state sets advance on every accepted sample so a mode change needs no clear.
   always_ff @(posedge clk) begin
      if (srst) begin
         for (int i = 0; i < N; i++) cnt_reg[i] <= '0;
         acc_reg <= '0;
         y_p_reg <= 1'b0;
         y_m_reg <= 1'b0;
      end else if (clr) begin
         for (int i = 0; i < N; i++) cnt_reg[i] <= '0;
         acc_reg <= '0;
      end else if (in_valid) begin
         for (int i = 0; i < N; i++) cnt_reg[i] <= cnt_next[i];
         acc_reg <= acc_next;
         if (mode_e'(mode) == POOL_AVG) begin
            y_p_reg <= avg_p;
            y_m_reg <= avg_m;
         end else begin
            y_p_reg <= tap_p[lead_idx];
            y_m_reg <= tap_m[lead_idx];
         end
      end
   end

   assign y_p = y_p_reg;
   assign y_m = y_m_reg;

endmodule

// File: rtl/stoch_signed_pool.sv
// Stochastic signed-bitstream 2-D pooling layer: static patch wiring with zero padding
// feeding one pooling unit per output pixel and channel.
module stoch_signed_pool
   import stoch_pool_pkg::*;
#(
   parameter int IM_HEIGHT = 12,
   parameter int IM_WIDTH  = 12,
   parameter int CHANNELS  = 3,
   parameter int KERNEL_H  = 2,
   parameter int KERNEL_W  = 2,
   parameter int PAD_H     = 0,
   parameter int PAD_W     = 0,
   parameter int STRIDE_H  = 2,
   parameter int STRIDE_W  = 2,
   parameter int CNT_W     = 8,
   localparam int OUT_H    = out_dim(IM_HEIGHT, PAD_H, KERNEL_H, STRIDE_H),
   localparam int OUT_W    = out_dim(IM_WIDTH, PAD_W, KERNEL_W, STRIDE_W)
) (
   input  logic                                          CLK,
   input  logic                                          RST,
   input  logic                                          mode,
   input  logic                                          clr,
   input  logic                                          in_valid,
   input  logic [IM_HEIGHT-1:0][IM_WIDTH-1:0][CHANNELS-1:0] x_p,
   input  logic [IM_HEIGHT-1:0][IM_WIDTH-1:0][CHANNELS-1:0] x_m,
   output logic                                          out_valid,
   output logic [OUT_H-1:0][OUT_W-1:0][CHANNELS-1:0]     y_p,
   output logic [OUT_H-1:0][OUT_W-1:0][CHANNELS-1:0]     y_m
);

   localparam int N = KERNEL_H * KERNEL_W;

   function automatic logic [N-1:0] pad_mask_f(input int r, input int c);
      logic [N-1:0] m;
      int           row, col;
      m = '0;
      for (int kh = 0; kh < KERNEL_H; kh++) begin
         for (int kw = 0; kw < KERNEL_W; kw++) begin
            row = r * STRIDE_H - PAD_H + kh;
            col = c * STRIDE_W - PAD_W + kw;
            if (row < 0 || row >= IM_HEIGHT || col < 0 || col >= IM_WIDTH)
               m[kh * KERNEL_W + kw] = 1'b1;
         end
      end
      return m;
   endfunction

   logic out_valid_reg;

   always_ff @(posedge CLK) begin
      if (RST) out_valid_reg <= 1'b0;
      else     out_valid_reg <= in_valid & ~clr;
   end

   assign out_valid = out_valid_reg;

   genvar gr, gc, gch, gi;
   generate
      for (gr = 0; gr < OUT_H; gr++) begin : g_row
         for (gc = 0; gc < OUT_W; gc++) begin : g_col
            localparam logic [N-1:0] PMASK = pad_mask_f(gr, gc);
            for (gch = 0; gch < CHANNELS; gch++) begin : g_ch
               logic [N-1:0] tap_p, tap_m;
               for (gi = 0; gi < N; gi++) begin : g_tap
                  localparam int ROW = gr * STRIDE_H - PAD_H + gi / KERNEL_W;
                  localparam int COL = gc * STRIDE_W - PAD_W + gi % KERNEL_W;
                  if (PMASK[gi]) begin : g_pad
                     assign tap_p[gi] = 1'b0;
                     assign tap_m[gi] = 1'b0;
                  end else begin : g_pix
                     assign tap_p[gi] = x_p[ROW][COL][gch];
                     assign tap_m[gi] = x_m[ROW][COL][gch];
                  end
               end
               stoch_signed_pool_unit #(
                  .N        (N),
                  .CNT_W    (CNT_W),
                  .PAD_MASK (PMASK)
               ) u_unit (
                  .clk      (CLK),
                  .srst     (RST),
                  .mode     (mode),
                  .clr      (clr),
                  .in_valid (in_valid),
                  .tap_p    (tap_p),
                  .tap_m    (tap_m),
                  .y_p      (y_p[gr][gc][gch]),
                  .y_m      (y_m[gr][gc][gch])
               );
            end
         end
      end
   endgenerate

endmodule

// File: tb/tb_stoch_signed_pool.sv
// Scoreboard bench: a 12x12x3 2x2/s2 instance checked cycle by cycle against a small
// behavioural model, plus a 3x3 padded instance for the pad-exclusion cases.
module tb_stoch_signed_pool;

   localparam int IH = 12, IW = 12, CH = 3, OH = 6, OW = 6, CW = 4;
   localparam int SAT = 7;
   localparam int BH = 3, BW = 3, BOH = 2, BOW = 2;

   typedef struct packed {
      logic [OH-1:0][OW-1:0][CH-1:0] p;
      logic [OH-1:0][OW-1:0][CH-1:0] m;
   } plane_t;

   logic clk = 1'b0;
   logic rst, mode, clr, in_valid;
   logic [IH-1:0][IW-1:0][CH-1:0]  xa_p, xa_m;
   logic [OH-1:0][OW-1:0][CH-1:0]  ya_p, ya_m;
   logic                           ova;
   logic [BH-1:0][BW-1:0][0:0]     xb_p, xb_m;
   logic [BOH-1:0][BOW-1:0][0:0]   yb_p, yb_m;
   logic                           ovb;

   plane_t sb_q[$];
   plane_t held;
   int     n_vec = 0;
   int     n_err = 0;
   int     mcnt [OH][OW][CH][4];
   int     macc [OH][OW][CH];

   always #5 clk = ~clk;

   stoch_signed_pool #(
      .IM_HEIGHT(IH), .IM_WIDTH(IW), .CHANNELS(CH), .KERNEL_H(2), .KERNEL_W(2),
      .PAD_H(0), .PAD_W(0), .STRIDE_H(2), .STRIDE_W(2), .CNT_W(CW)
   ) dut_a (
      .CLK(clk), .RST(rst), .mode(mode), .clr(clr), .in_valid(in_valid),
      .x_p(xa_p), .x_m(xa_m), .out_valid(ova), .y_p(ya_p), .y_m(ya_m)
   );

   stoch_signed_pool #(
      .IM_HEIGHT(BH), .IM_WIDTH(BW), .CHANNELS(1), .KERNEL_H(3), .KERNEL_W(3),
      .PAD_H(1), .PAD_W(1), .STRIDE_H(2), .STRIDE_W(2), .CNT_W(8)
   ) dut_b (
      .CLK(clk), .RST(rst), .mode(mode), .clr(clr), .in_valid(in_valid),
      .x_p(xb_p), .x_m(xb_m), .out_valid(ovb), .y_p(yb_p), .y_m(yb_m)
   );

   task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic model_clear();
      for (int r = 0; r < OH; r++)
         for (int c = 0; c < OW; c++)
            for (int ch = 0; ch < CH; ch++) begin
               macc[r][c][ch] = 0;
               for (int i = 0; i < 4; i++) mcnt[r][c][ch][i] = 0;
            end
   endtask

   // Predicts the plane produced by the upcoming edge from the inputs now on the pins.
   task automatic model_step(output logic exp_ov);
      plane_t e;
      int     d [4];
      logic   tp [4];
      logic   tm [4];
      int     lead, s, a, n;
      logic   ap, am;
      e = '0;
      exp_ov = 1'b0;
      if (rst) begin
         model_clear();
         held = '0;
      end else if (clr) begin
         model_clear();
      end else if (in_valid) begin
         exp_ov = 1'b1;
         for (int r = 0; r < OH; r++)
            for (int c = 0; c < OW; c++)
               for (int ch = 0; ch < CH; ch++) begin
                  s = 0;
                  for (int i = 0; i < 4; i++) begin
                     tp[i] = xa_p[2 * r + i / 2][2 * c + i % 2][ch];
                     tm[i] = xa_m[2 * r + i / 2][2 * c + i % 2][ch];
                     d[i]  = int'(tp[i]) - int'(tm[i]);
                     s     = s + d[i];
                  end
                  lead = 0;
                  for (int i = 1; i < 4; i++)
                     if (mcnt[r][c][ch][i] > mcnt[r][c][ch][lead]) lead = i;
                  a  = macc[r][c][ch] + s;
                  ap = 1'b0;
                  am = 1'b0;
                  if (a >= 4) begin
                     ap = 1'b1; a = a - 4;
                  end else if (a <= -4) begin
                     am = 1'b1; a = a + 4;
                  end
                  macc[r][c][ch] = a;
                  e.p[r][c][ch] = mode ? ap : tp[lead];
                  e.m[r][c][ch] = mode ? am : tm[lead];
                  for (int i = 0; i < 4; i++) begin
                     n = mcnt[r][c][ch][i] + d[i];
                     if (n > SAT)  n = SAT;
                     if (n < -SAT) n = -SAT;
                     mcnt[r][c][ch][i] = n;
                  end
               end
         sb_q.push_back(e);
      end
   endtask

   task automatic step();
      logic   exp_ov;
      plane_t e;
      model_step(exp_ov);
      @(posedge clk);
      #1;
      check_eq("out_valid", 256'(ova), 256'(exp_ov));
      if (ova) begin
         if (sb_q.size() == 0) check_eq("sb_underflow", 256'(sb_q.size()), 256'(1));
         else begin
            e = sb_q.pop_front();
            held = e;
         end
      end
      sb_q.delete();
      check_eq("y_plane", 256'({ya_p, ya_m}), 256'(held));
   endtask

   task automatic rand_x();
      for (int r = 0; r < IH; r++)
         for (int c = 0; c < IW; c++)
            for (int ch = 0; ch < CH; ch++) begin
               xa_p[r][c][ch] = 1'($urandom_range(0, 1));
               xa_m[r][c][ch] = 1'($urandom_range(0, 1));
            end
   endtask

   // Same tap values in every window; a zero tap is driven as p=m=1.
   task automatic set_taps(input int v0, input int v1, input int v2, input int v3);
      int v;
      for (int r = 0; r < IH; r++)
         for (int c = 0; c < IW; c++)
            for (int ch = 0; ch < CH; ch++) begin
               case ((r % 2) * 2 + (c % 2))
                  0:       v = v0;
                  1:       v = v1;
                  2:       v = v2;
                  default: v = v3;
               endcase
               xa_p[r][c][ch] = (v >= 0);
               xa_m[r][c][ch] = (v <= 0);
            end
   endtask

   int net;
   int netb [4];

   initial begin
      rst = 1'b1; mode = 1'b0; clr = 1'b0; in_valid = 1'b1;
      xb_p = '0; xb_m = '0; held = '0;
      model_clear();
      rand_x();
      step();
      rand_x();
      step();
      rst = 1'b0;
      rand_x();
      step();
      step();

      // Max mode with a tie between taps 0 and 3.
      clr = 1'b1; in_valid = 1'b0; step();
      clr = 1'b0; in_valid = 1'b1; mode = 1'b0;
      set_taps(1, 0, -1, 1);
      repeat (10) begin
         step();
         check_eq("max_lead", 256'({ya_p[0][0][0], ya_m[0][0][0]}), 256'(2'b10));
      end

      // Saturation: tap0 clamps at 7 and tap1 only ever ties it.
      clr = 1'b1; step(); clr = 1'b0;
      set_taps(1, 0, 0, 0);
      repeat (20) step();
      set_taps(0, 1, 0, 0);
      repeat (20) begin
         step();
         check_eq("sat_lead", 256'({ya_p[0][0][0], ya_m[0][0][0]}), 256'(2'b11));
      end

      // Average mode, mean +1/4.
      clr = 1'b1; step(); clr = 1'b0;
      mode = 1'b1;
      set_taps(1, 1, -1, 0);
      net = 0;
      repeat (400) begin
         step();
         if (ova) net += int'(ya_p[0][0][0]) - int'(ya_m[0][0][0]);
      end
      check_eq("avg_net", 256'(net), 256'(100));

      // Padded 3x3 instance: every window sees four real -1 taps and five pads.
      set_taps(0, 0, 0, 0);
      xb_p = '0; xb_m = '1;
      clr = 1'b1; step(); clr = 1'b0;
      mode = 1'b0;
      repeat (10) begin
         step();
         check_eq("pad_ov", 256'(ovb), 256'(1));
         check_eq("pad_max", 256'({yb_p, yb_m}), 256'(8'b0000_1111));
      end
      clr = 1'b1; step(); clr = 1'b0;
      mode = 1'b1;
      for (int w = 0; w < 4; w++) netb[w] = 0;
      repeat (400) begin
         step();
         if (ovb)
            for (int w = 0; w < 4; w++)
               netb[w] += int'(yb_m[w / 2][w % 2][0]) - int'(yb_p[w / 2][w % 2][0]);
      end
      for (int w = 0; w < 4; w++) check_eq($sformatf("pad_avg_net%0d", w), 256'(netb[w]), 256'(177));

      // clr together with in_valid drops the sample, then random traffic with mode toggling.
      rand_x();
      clr = 1'b1; in_valid = 1'b1; step();
      clr = 1'b0;
      for (int k = 0; k < 300; k++) begin
         rand_x();
         mode     = (k < 60) ? k[0] : 1'($urandom_range(0, 1));
         in_valid = (k < 60) ? 1'b1 : ($urandom_range(0, 9) != 0);
         clr      = (k >= 60) && ($urandom_range(0, 29) == 0);
         rst      = (k == 150);
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
